// File: rtl/bram_dma_if.sv
// Bus bundle between the block copy/fill engine and its environment (control
// side plus one bram port). The engine uses the slave view.
interface bram_dma_if #(
  parameter int P_DATA_WIDTH    = 16,
  parameter int P_ADDRESS_WIDTH = 10
);
  logic                       start;
  logic                       mode;
  logic [P_ADDRESS_WIDTH-1:0] srcAddress;
  logic [P_ADDRESS_WIDTH-1:0] dstAddress;
  logic [P_ADDRESS_WIDTH:0]   length;
  logic [P_DATA_WIDTH-1:0]    fillData;
  logic                       busy;
  logic                       done;
  logic [P_ADDRESS_WIDTH-1:0] bramAddress;
  logic [P_DATA_WIDTH-1:0]    bramWrData;
  logic                       bramWriteEnable;
  logic [P_DATA_WIDTH-1:0]    bramRdData;

  modport master (
    output start, mode, srcAddress, dstAddress, length, fillData, bramRdData,
    input  busy, done, bramAddress, bramWrData, bramWriteEnable
  );

  modport slave (
    input  start, mode, srcAddress, dstAddress, length, fillData, bramRdData,
    output busy, done, bramAddress, bramWrData, bramWriteEnable
  );
endinterface

// File: rtl/bram_dma.sv
// Block copy/fill engine driving one bram port: copies a word range or fills
// a range with a constant, ascending, with modulo address arithmetic.
module bram_dma #(
  parameter int P_DATA_WIDTH    = 16,
  parameter int P_ADDRESS_WIDTH = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  bram_dma_if.slave     bus_io
);
  localparam int AW = P_ADDRESS_WIDTH;
  localparam int DW = P_DATA_WIDTH;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, COPY_RD, COPY_WR, FILL_WR, DONE} state_e;

  state_e          state_q;
  logic [AW-1:0]   srcAddr_q;
  logic [AW-1:0]   dstAddr_q;
  logic [CW-1:0]   length_q;
  logic [CW-1:0]   count_q;
  logic [DW-1:0]   wrData_q;
  logic [AW-1:0]   address_q;
  logic            we_q;
  logic            busy_q;
  logic            done_q;

  logic [CW-1:0]   countNext_d;
  logic            lastWord_d;

  always_comb begin
    countNext_d = count_q + CW'(1);
    lastWord_d  = (count_q == (length_q - CW'(1)));
  end

  // Outputs are registered alongside the state, so each state's bus values
  // are prepared on the edge that enters it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      srcAddr_q <= '0;
      dstAddr_q <= '0;
      length_q  <= '0;
      count_q   <= '0;
      wrData_q  <= '0;
      address_q <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus_io.start) begin
            srcAddr_q <= bus_io.srcAddress;
            dstAddr_q <= bus_io.dstAddress;
            length_q  <= bus_io.length;
            count_q   <= '0;
            if (bus_io.length == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (!bus_io.mode) begin
              state_q   <= COPY_RD;
              address_q <= bus_io.srcAddress;
              busy_q    <= 1'b1;
            end else begin
              state_q   <= FILL_WR;
              address_q <= bus_io.dstAddress;
              wrData_q  <= bus_io.fillData;
              we_q      <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
        end
        COPY_RD: begin
          state_q   <= COPY_WR;
          address_q <= dstAddr_q + count_q[AW-1:0];
          we_q      <= 1'b1;
        end
        COPY_WR, FILL_WR: begin
          count_q <= countNext_d;
          if (lastWord_d) begin
            state_q   <= DONE;
            address_q <= '0;
            wrData_q  <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else if (state_q == COPY_WR) begin
            state_q   <= COPY_RD;
            address_q <= srcAddr_q + countNext_d[AW-1:0];
            we_q      <= 1'b0;
          end else begin
            address_q <= dstAddr_q + countNext_d[AW-1:0];
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Read data only arrives the cycle after its address, so copy writes pass it straight through.
  always_comb begin
    bus_io.busy            = busy_q;
    bus_io.done            = done_q;
    bus_io.bramAddress     = address_q;
    bus_io.bramWriteEnable = we_q;
    bus_io.bramWrData      = (state_q == COPY_WR) ? bus_io.bramRdData : wrData_q;
  end
endmodule
